// File: rtl/ram_uart_pkg.sv
// Shared definitions for ram_uart_streamer: FSM state encoding and 8N1 frame constants.
package ram_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StSend,
    StNext,
    StDone
  } state_e;

  localparam logic        StartBit  = 1'b0;
  localparam logic        StopBit   = 1'b1;
  localparam int unsigned FrameBits = 10;
  localparam int unsigned ByteW     = 8;

endpackage

// File: rtl/uart_tx_hs.sv
// Valid/ready 8N1 UART transmitter. A byte is taken when tx_valid && tx_ready; the line
// falls the next cycle and tx_ready returns the cycle after the stop bit ends.
module uart_tx_hs
  import ram_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       txd
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic                 active_q;
  logic [CntW-1:0]      baud_q;
  logic [3:0]           bit_q;
  logic [FrameBits-1:0] frame_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      frame_q  <= '1;
    end else if (!active_q) begin
      if (tx_valid) begin
        active_q <= 1'b1;
        baud_q   <= '0;
        bit_q    <= '0;
        frame_q  <= {StopBit, tx_data, StartBit};
      end
    end else if (baud_q == CntW'(CLK_DIV - 1)) begin
      baud_q <= '0;
      if (bit_q == 4'(FrameBits - 1)) begin
        active_q <= 1'b0;
      end else begin
        bit_q   <= bit_q + 1'b1;
        frame_q <= {StopBit, frame_q[FrameBits-1:1]};
      end
    end else begin
      baud_q <= baud_q + 1'b1;
    end
  end

  // Line is forced idle whenever no frame is active, so an async reset drops it high at once.
  assign txd      = active_q ? frame_q[0] : StopBit;
  assign tx_ready = !active_q;

endmodule

// File: rtl/ram_uart_streamer.sv
// RAM-to-UART dump engine: reads `length` words from `base_addr` and sends them LSB byte first.
// Define RAM_UART_CHECKSUM_EN to append a modulo-256 sum trailer byte on non-aborted runs.
module ram_uart_streamer
  import ram_uart_pkg::*;
#(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned RAM_LAT = 1,
  parameter int unsigned CLK_DIV = 434
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] address,
  input  logic [WORD_W-1:0] rd_data,
  output logic              uart_txd,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int unsigned NBYTES = WORD_W / 8;
  localparam int unsigned BcW    = $clog2(NBYTES + 1);
  localparam int unsigned LatW   = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [ADDR_W:0] RemainOne = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BcW-1:0]    left_q, left_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic              aborted_q, aborted_d;
  logic              done_q;
  logic              tx_valid, tx_ready;
  logic              abort_now;
`ifdef RAM_UART_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              trailer_q, trailer_d;
`endif

  // A pending abort is remembered in aborted_q, which start clears.
  assign abort_now = abort | aborted_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    remain_d  = remain_q;
    word_d    = word_q;
    left_d    = left_q;
    lat_d     = lat_q;
    aborted_d = aborted_q;
    rd_en     = 1'b0;
    tx_valid  = 1'b0;
`ifdef RAM_UART_CHECKSUM_EN
    csum_d    = csum_q;
    trailer_d = trailer_q;
`endif
    if (abort && state_q != StIdle && state_q != StDone) aborted_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ptr_d     = base_addr;
          remain_d  = length;
          aborted_d = 1'b0;
`ifdef RAM_UART_CHECKSUM_EN
          csum_d    = '0;
          trailer_d = 1'b0;
`endif
          state_d   = (length == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        rd_en   = 1'b1;
        lat_d   = '0;
        state_d = abort_now ? StDone : StWait;
      end
      StWait: begin
        if (abort_now) begin
          state_d = StDone;
        end else if (lat_q == LatW'(RAM_LAT - 1)) begin
          word_d  = rd_data;
          left_d  = BcW'(NBYTES);
          state_d = StSend;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StSend: begin
        // No new byte is offered once aborting; the frame on the line still finishes.
        tx_valid = (left_q != '0) && !abort_now;
        if (tx_valid && tx_ready) begin
          word_d = word_q >> ByteW;
          left_d = left_q - 1'b1;
`ifdef RAM_UART_CHECKSUM_EN
          if (!trailer_q) csum_d = csum_q + word_q[ByteW-1:0];
`endif
        end else if (tx_ready) begin
          state_d = abort_now ? StDone : StNext;
        end
      end
      StNext: begin
        if (abort_now) begin
          state_d = StDone;
`ifdef RAM_UART_CHECKSUM_EN
        end else if (trailer_q) begin
          state_d = StDone;
        end else if (remain_q == RemainOne) begin
          word_d    = WORD_W'(csum_q);
          left_d    = BcW'(1);
          trailer_d = 1'b1;
          state_d   = StSend;
`endif
        end else begin
          ptr_d    = ptr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          state_d  = (remain_q == RemainOne) ? StDone : StRead;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      remain_q  <= '0;
      word_q    <= '0;
      left_q    <= '0;
      lat_q     <= '0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      remain_q  <= remain_d;
      word_q    <= word_d;
      left_q    <= left_d;
      lat_q     <= lat_d;
      aborted_q <= aborted_d;
      done_q    <= (state_q == StDone);
    end
  end

`ifdef RAM_UART_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q    <= '0;
      trailer_q <= 1'b0;
    end else begin
      csum_q    <= csum_d;
      trailer_q <= trailer_d;
    end
  end
`endif

  uart_tx_hs #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .tx_valid (tx_valid),
    .tx_data  (word_q[ByteW-1:0]),
    .tx_ready (tx_ready),
    .txd      (uart_txd)
  );

  assign address = ptr_q;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_ram_uart_streamer.sv
// Bench for ram_uart_streamer: table of runs plus directed corner sequences, checked against a
// queue-based model of the expected byte stream and RAM address sequence.
module tb_ram_uart_streamer;

  localparam int AW    = 4;
  localparam int LW    = AW + 1;
  localparam int WW    = 32;
  localparam int LAT   = 2;
  localparam int DIV   = 4;
  localparam int NB    = WW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          abort = 1'b0;
  logic          rd_en;
  logic [AW-1:0] address;
  logic [WW-1:0] rd_data;
  logic          uart_txd, busy, done, aborted;

  logic [WW-1:0] mem  [DEPTH];
  logic [WW-1:0] pipe [LAT];

  int n_total = 0;
  int n_pass  = 0;
  byte unsigned rx_q[$];
  byte unsigned exp_bytes[$];
  int addr_q[$];
  int exp_addr[$];
  int done_cnt = 0;
  int low_samples = 0;
  bit mon_off = 1'b0;

  typedef struct {
    int base;
    int len;
    int abort_word;
    bit abort_at_start;
    bit start_busy;
    bit exp_aborted;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  ram_uart_streamer #(
    .ADDR_W  (AW),
    .WORD_W  (WW),
    .RAM_LAT (LAT),
    .CLK_DIV (DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .abort     (abort),
    .rd_en     (rd_en),
    .address   (address),
    .rd_data   (rd_data),
    .uart_txd  (uart_txd),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  // RAM with RAM_LAT cycles of read latency; unrequested slots carry a poison word.
  always @(posedge clk) begin
    pipe[0] <= rd_en ? mem[address] : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rd_data = pipe[LAT-1];

  always @(negedge clk) begin
    if (reset && rd_en) addr_q.push_back(int'(address));
    if (reset && done) done_cnt++;
    if (!uart_txd) low_samples++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Line receiver: samples the middle of each bit after a falling edge.
  initial begin : uart_mon
    logic [7:0] b;
    logic       s0, s1;
    forever begin
      @(negedge clk);
      if (reset && !mon_off && !uart_txd) begin
        repeat (DIV / 2) @(negedge clk);
        s0 = uart_txd;
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) @(negedge clk);
          b[k] = uart_txd;
        end
        repeat (DIV) @(negedge clk);
        s1 = uart_txd;
        if (!mon_off) begin
          check("start_bit", 32'(s0), 32'd0);
          check("stop_bit", 32'(s1), 32'd1);
          rx_q.push_back(b);
        end
      end
    end
  end

  task automatic fill_random();
    for (int j = 0; j < DEPTH; j++) mem[j] = $urandom();
  endtask

  task automatic run_case(input int base, input int len, input int abort_word,
                          input bit abort_at_start, input bit start_busy, input bit exp_ab);
    int nw, budget, cyc;
    logic [WW-1:0] w;
    byte unsigned sum;
    bit seen;
    exp_bytes.delete(); exp_addr.delete(); rx_q.delete(); addr_q.delete();
    done_cnt = 0;
    sum = 0;
    nw = (abort_word >= 0) ? abort_word + 1 : len;
    for (int i = 0; i < nw; i++) begin
      exp_addr.push_back((base + i) % DEPTH);
      w = mem[(base + i) % DEPTH];
      for (int bi = 0; bi < NB; bi++) begin
        if (!(abort_word >= 0 && i == abort_word && bi > 0)) begin
          exp_bytes.push_back(w[8*bi +: 8]);
          sum = sum + w[8*bi +: 8];
        end
      end
    end
`ifdef RAM_UART_CHECKSUM_EN
    if (abort_word < 0 && len > 0) exp_bytes.push_back(sum);
`endif
    @(negedge clk);
    base_addr = AW'(base);
    length    = LW'(len);
    start     = 1'b1;
    abort     = abort_at_start;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("first_rd_en", 32'(rd_en), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
    if (start_busy) begin
      repeat (30) @(negedge clk);
      base_addr = '0;
      length    = LW'(1);
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (abort_word >= 0) begin
      cyc = 0;
      while (rx_q.size() < abort_word * NB && cyc < 20000) begin
        @(negedge clk);
        cyc++;
      end
      while (uart_txd && cyc < 20000) begin
        @(negedge clk);
        cyc++;
      end
      check("abort_sync", 32'(cyc < 20000), 32'd1);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    budget = (len * NB + 1) * (10 * DIV + 2) + len * (LAT + 8) + 50;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) check("busy_low_at_done", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("aborted", 32'(aborted), 32'(exp_ab));
    check("rx_count", 32'(rx_q.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size(); i++)
      check($sformatf("byte%0d", i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF,
            32'(exp_bytes[i]));
    check("rd_en_count", 32'(addr_q.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++)
      check($sformatf("addr%0d", i), (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hFFFF_FFFF,
            32'(exp_addr[i]));
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int lows, cyc, base, len, aw;
    vecs[0] = '{5, 2, -1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{14, 4, -1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{0, 16, -1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{3, 8, 2, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{7, 3, -1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{10, 5, -1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{15, 1, -1, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      fill_random();
      if (i == 0) begin
        mem[5] = 32'h1122_3344;
        mem[6] = 32'hAABB_CCDD;
      end
      run_case(vecs[i].base, vecs[i].len, vecs[i].abort_word, vecs[i].abort_at_start,
               vecs[i].start_busy, vecs[i].exp_aborted);
      if (i == 0) begin
        check("order_first", (rx_q.size() >= 8) ? 32'(rx_q[0]) : 32'hFFFF_FFFF, 32'h44);
        check("order_last", (rx_q.size() >= 8) ? 32'(rx_q[7]) : 32'hFFFF_FFFF, 32'hAA);
      end
    end

    // length 0, with start held into the busy cycle
    lows = low_samples;
    addr_q.delete();
    done_cnt = 0;
    @(negedge clk);
    base_addr = AW'(3);
    length    = '0;
    start     = 1'b1;
    @(negedge clk);
    check("len0_busy", 32'(busy), 32'd1);
    check("len0_done_early", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy_drop", 32'(busy), 32'd0);
    @(negedge clk);
    check("len0_done_width", 32'(done), 32'd0);
    repeat (20) @(negedge clk);
    check("len0_no_rd_en", 32'(addr_q.size()), 32'd0);
    check("len0_line_high", 32'(low_samples - lows), 32'd0);
    check("len0_done_cnt", 32'(done_cnt), 32'd1);
    check("len0_idle", 32'(busy), 32'd0);

    for (int r = 0; r < 4; r++) begin
      fill_random();
      base = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(1, 6);
      aw   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
      run_case(base, len, aw, 1'b0, 1'b0, aw >= 0);
    end

`ifdef RAM_UART_CHECKSUM_EN
    fill_random();
    mem[0] = 32'h00F0_2010;
    run_case(0, 1, -1, 1'b0, 1'b0, 1'b0);
    check("csum_trailer", (rx_q.size() == 5) ? 32'(rx_q[4]) : 32'hFFFF_FFFF, 32'h20);
`endif

    // asynchronous reset in the middle of a frame
    fill_random();
    @(negedge clk);
    base_addr = AW'(9);
    length    = LW'(3);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (uart_txd && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_sync", 32'(cyc < 2000), 32'd1);
    repeat (5) @(negedge clk);
    mon_off = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_mid_txd", 32'(uart_txd), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_rd_en", 32'(rd_en), 32'd0);
    check("rst_mid_address", 32'(address), 32'd0);
    check("rst_mid_aborted", 32'(aborted), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check("rst_after_txd", 32'(uart_txd), 32'd1);
    check("rst_after_busy", 32'(busy), 32'd0);
    mon_off = 1'b0;
    rx_q.delete();

    fill_random();
    run_case(2, 2, -1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_uart_streamer.md
# ram_uart_streamer

Parametrised RAM-to-UART dump engine. On a start pulse it reads `length` words from a synchronous RAM starting at `base_addr` and serialises each word byte-by-byte, LSB byte first, over a built-in 8N1 UART transmitter. It then pulses `done`. It sits between the result RAMs and the debug/host UART, and generalises the fixed 32-byte, 8-bit reader to any word width, length, base address and RAM latency, with abort support.

## Interface
- `ADDR_W`, 15, RAM address width.
- `WORD_W`, 8, RAM word width; must be a multiple of 8; `NBYTES = WORD_W/8`.
- `RAM_LAT`, 1, RAM read latency in cycles (1..4) from `rd_en` to valid `rd_data`.
- `CLK_DIV`, 434, clock cycles per UART bit (≥ 2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address; captured at start.
- `length`  in  ADDR_W+1  number of words; captured at start.
- `abort`  in  1  stop after the in-flight byte.
- `rd_en`  out  1  RAM read strobe, one cycle per word.
- `address`  out  ADDR_W  RAM read address.
- `rd_data`  in  WORD_W  RAM read data.
- `uart_txd`  out  1  serial line; idle high.
- `busy`  out  1  high from the cycle after start until `done`.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  sticky; set on an aborted run, cleared by the next start.

## Operation
- Reset values: `uart_txd`=1, `busy`=0, `done`=0, `aborted`=0, `rd_en`=0, `address`=0, FSM in IDLE.
- FSM states:
  - IDLE: on `start`, capture `base_addr` and `length`, clear `aborted`. Go to DONE if `length`==0, else to READ.
  - READ: drive `address`=current pointer and `rd_en`=1 for one cycle, then go to WAIT.
  - WAIT: count RAM_LAT cycles, latch `rd_data` into the shift register, then go to SEND.
  - SEND: hand bytes to the UART tx submodule, LSB byte first, `NBYTES` handshakes. After the last byte is accepted and its frame completes, go to NEXT.
  - NEXT: increment the pointer modulo 2^ADDR_W, so addresses wrap past the top. Decrement the remaining count. Go to READ if the count is nonzero, else to DONE.
  - DONE: pulse `done` for one cycle, drop `busy`, return to IDLE.
- `abort` is honoured in any non-IDLE state. The byte frame currently on the line completes, then the FSM goes to DONE with `aborted`=1.
- `start` while busy is ignored. `start` and `abort` in the same cycle in IDLE: start wins, and the abort is ignored.
- `length` maximum is 2^ADDR_W; the full address space is dumped exactly once.

## Timing
- UART frame per byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts CLK_DIV cycles, so a frame is 10·CLK_DIV cycles.
- UART tx accept rule: a byte is accepted on a cycle where `tx_valid` and `tx_ready` are both high. `uart_txd` falls on the next cycle. `tx_ready` rises the cycle after the stop bit ends.
- Start to first `rd_en`: 1 cycle. `rd_en` to data latch: RAM_LAT cycles. Latch to first start bit: 2 cycles.
- Bytes within a word are back-to-back: at most 1 idle cycle between consecutive frames. Inter-word gap is at most RAM_LAT+4 cycles of idle-high line.
- `done` asserts 1 cycle after the final stop bit (or 2 cycles after `start` when `length`=0).
- An asynchronous reset mid-frame forces `uart_txd` high immediately; the partial frame is lost.

## Configuration
- `RAM_UART_CHECKSUM_EN` defined: after the last word, one extra byte is sent. It is the 8-bit modulo-256 sum of all transmitted data bytes. It is not sent on an aborted run. `done` follows its stop bit.
- Not defined: no trailer byte, and no checksum register exists.

## Structure
- Shared package `ram_uart_pkg`: FSM state enum and UART frame constants (start/stop bit values, 10 bits per frame).
- Sub-module `uart_tx_hs`: valid/ready 8N1 transmitter parameterised by CLK_DIV, holding the baud counter and bit index.
- Top level: FSM, address pointer, remaining count, word shift register, RAM_LAT delay counter, optional checksum.

## Test plan
- Config WORD_W=8, RAM_LAT=1, CLK_DIV=4, base=0, length=32, RAM[i]=i -> bytes 0x00..0x1F on the line, 32 `rd_en` pulses, one `done`, `aborted`=0.
- Config WORD_W=32, RAM_LAT=2, base=5, length=2, RAM[5]=0x11223344, RAM[6]=0xAABBCCDD -> byte order 44 33 22 11 DD CC BB AA; each frame is 40 cycles at CLK_DIV=4.
- Config ADDR_W=4, base=14, length=4 -> addresses 14, 15, 0, 1 (wrap); `done` after the 4th word.
- Stimulus length=0 -> no `rd_en`, line stays high, `done` 2 cycles after start; a second start during busy is ignored.
- Stimulus abort mid-byte of word 3 of 8 -> that frame completes intact, no further `rd_en`, `done` pulse, `aborted`=1; async reset mid-frame -> `uart_txd`=1 and all outputs at reset values.
- With `RAM_UART_CHECKSUM_EN`, bytes 0x10, 0x20, 0xF0 -> trailer 0x20 sent before `done`.
